mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single memory2c port between the instruction-fetch requester (PC path) and the data load/store requester.
- Sequences each access over MEM_LAT cycles, registers the read data, and returns it with a one-cycle valid pulse.
- Arbitration is data-priority, with a starvation guard that forces a fetch grant after MAX_WAIT consecutive data wins.
- Sits between the pc_register/adder fetch path, the load/store unit, and memory2c.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles the memory port is held per access (1..15).
- MAX_WAIT, 4, consecutive data grants allowed while if_req is pending before fetch is forced (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request; held with d_wr/d_addr/d_wdata until d_gnt
- d_wr  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle pulse; read data, or write-done ack
- d_rdata  out  DATA_W  load data (0 for writes)
- mem_enable  out  1  to memory2c enable
- mem_wr  out  1  to memory2c wr
- mem_addr  out  ADDR_W  to memory2c addr
- mem_data_in  out  DATA_W  to memory2c data_in
- mem_data_out  in  DATA_W  from memory2c data_out (combinational read)

Behaviour:
Clock and reset:
- One clock; reset is synchronous and active-high.
- On reset: state IDLE; latency counter 0; wait counter 0; any in-flight access abandoned with no rvalid.
- All outputs are 0 during and after reset: gnt, rvalid, rdata, mem_enable, mem_wr, mem_addr, mem_data_in.

States:
- IDLE: may grant.
- BUSY: access in flight.

IDLE, grant decision (combinational on req and wait counter):
- d_req only: grant data.
- if_req only: grant fetch.
- Both requesting: grant data unless wait counter == MAX_WAIT, in which case grant fetch.
- At most one gnt per cycle; gnts are only asserted in IDLE.
- On a grant: latch addr, wr (fetch = read), wdata and an owner bit; go to BUSY; clear the latency counter.

BUSY:
- Lasts exactly MEM_LAT cycles.
- mem_enable = 1; mem_addr and mem_data_in driven from the latched values and stable for the whole access.
- mem_wr = 1 only in the final BUSY cycle, and only for a data write, so there is exactly one write edge.
- Final BUSY cycle: capture mem_data_out into the owner's rdata register (d_rdata is 0 for writes); next state IDLE.

Response:
- The owner's rvalid pulses for one cycle, the first IDLE cycle after BUSY.
- A new grant may be issued in that same cycle.
- Timing: gnt at cycle T; BUSY T+1..T+MEM_LAT; rvalid at T+MEM_LAT+1.
- Peak throughput: one access per MEM_LAT+1 cycles.
- rdata holds its value until that requester's next rvalid.

Outside BUSY:
- mem_enable = 0 and mem_wr = 0.
- mem_addr and mem_data_in keep their last latched values.

Wait counter (0..MAX_WAIT, saturating):
- Updated only in IDLE cycles with a grant.
- Data grant with if_req high: +1, saturating.
- Fetch grant: cleared to 0.
- Any IDLE cycle with if_req low: cleared to 0.

Protocol violations (undefined, not checked):
- A requester withdrawing or changing its request before gnt.

Test Plan:
- Reset -> hold reset 2 cycles with both reqs high -> all outputs 0, no gnt; after release, first gnt in the first IDLE cycle.
- Fetch read, MEM_LAT=1, if_addr=0x8, memory word 0x12345678 -> if_gnt at T, mem_enable=1 and mem_addr=0x8 at T+1, if_rvalid=1 and if_rdata=0x12345678 at T+2.
- Data write then fetch: d_wr=1, d_addr=0x40, d_wdata=0xDEADBEEF; then if_req at 0x40 -> mem_wr high exactly 1 cycle; d_rvalid pulse with d_rdata=0; later if_rdata=0xDEADBEEF.
- Contention, MAX_WAIT=4, both reqs held continuously -> grant order D,D,D,D,I,D,D,D,D,I; each grant spaced MEM_LAT+1 cycles.
- Reset asserted in the middle of a BUSY write (MEM_LAT=3, cycle 2) -> mem_wr never asserts, no d_rvalid; memory at d_addr unchanged.
- MEM_LAT=3, back-to-back fetches at 0x0, 0x4, 0x8 -> if_gnt every 4 cycles; mem_addr stable 3 cycles each; if_rvalid coincides with the next if_gnt.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle between the fetch requester, the data requester, the arbiter and memory2c.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   // fetch requester
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   // data requester
   logic              d_req;
   logic              d_wr;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   // memory2c side
   logic              mem_enable;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data_in;
   logic [DATA_W-1:0] mem_data_out;

   // arbiter side
   modport slave (
      input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_data_out,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
      output mem_enable, mem_wr, mem_addr, mem_data_in
   );

   // requesters and memory side
   modport master (
      output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_data_out,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
      input  mem_enable, mem_wr, mem_addr, mem_data_in
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory2c port between instruction fetch and data load/store.
// Data has priority; a wait counter forces a fetch grant after MAX_WAIT data wins.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MEM_LAT  = 1,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   mem_port_arbiter_if.slave   bus
);
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);
   localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  lat_q, lat_d;
   logic [CNT_W-1:0]  wait_q, wait_d;
   logic              owner_q, owner_d;   // 1 = data access in flight
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              if_rvalid_q, if_rvalid_d;
   logic              d_rvalid_q, d_rvalid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              grant_d_c, grant_if_c, last_c;

   // Next-state, grant decision, latency/wait counters and response capture.
   always_comb begin
      state_d     = state_q;
      lat_d       = lat_q;
      wait_d      = wait_q;
      owner_d     = owner_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if_rvalid_d = 1'b0;
      d_rvalid_d  = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      grant_d_c   = 1'b0;
      grant_if_c  = 1'b0;
      last_c      = 1'b0;

      case (state_q)
         IDLE: begin
            if (!reset) begin
               if (bus.d_req && !(bus.if_req && (wait_q == WAIT_MAX))) begin
                  grant_d_c = 1'b1;
               end else if (bus.if_req) begin
                  grant_if_c = 1'b1;
               end
            end

            if (!bus.if_req || grant_if_c) begin
               wait_d = '0;
            end else if (grant_d_c && (wait_q != WAIT_MAX)) begin
               wait_d = wait_q + CNT_W'(1);
            end

            if (grant_d_c || grant_if_c) begin
               state_d = BUSY;
               lat_d   = '0;
               owner_d = grant_d_c;
               wr_d    = grant_d_c & bus.d_wr;
               addr_d  = grant_d_c ? bus.d_addr : bus.if_addr;
               wdata_d = grant_d_c ? bus.d_wdata : '0;
            end
         end

         BUSY: begin
            if (lat_q == LAT_LAST) begin
               last_c  = 1'b1;
               state_d = IDLE;
               if (owner_q) begin
                  d_rvalid_d = 1'b1;
                  d_rdata_d  = wr_q ? '0 : bus.mem_data_out;
               end else begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = bus.mem_data_out;
               end
            end else begin
               lat_d = lat_q + CNT_W'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any access in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         lat_q       <= '0;
         wait_q      <= '0;
         owner_q     <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         wait_q      <= wait_d;
         owner_q     <= owner_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         if_rvalid_q <= if_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   // Grants are combinational handshakes; the write strobe fires only in the final BUSY cycle.
   assign bus.if_gnt      = grant_if_c;
   assign bus.d_gnt       = grant_d_c;
   assign bus.mem_enable  = (state_q == BUSY) & ~reset;
   assign bus.mem_wr      = last_c & owner_q & wr_q & ~reset;
   assign bus.mem_addr    = addr_q;
   assign bus.mem_data_in = wdata_q;
   assign bus.if_rvalid   = if_rvalid_q;
   assign bus.if_rdata    = if_rdata_q;
   assign bus.d_rvalid    = d_rvalid_q;
   assign bus.d_rdata     = d_rdata_q;

endmodule
